pipe_barrel_shifter: RTL and testbench



---
 rtl/pipe_barrel_shifter.sv | 94 +++++++++
 tb/tb_pipe_barrel_shifter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_barrel_shifter.sv
// pipe_barrel_shifter: S-stage log shifter (SLL/SRL/SRA/ROL), one shift level per stage, bubble-collapsing valid/ready.
// Define PIPE_BARREL_STICKY_EN to build the shifted-out sticky bit; otherwise out_sticky is tied to 0.
module pipe_barrel_shifter #(
    parameter int N = 16,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [S-1:0] in_shamt,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_sticky
);
    logic unused_last;

    for (genvar i = 0; i < S; i++) begin : g_stage
        localparam int K  = 1 << i;
        localparam int KR = K % N;
        // Masks of the bits a level-K right/left shift pushes out; they saturate to all ones once K >= N.
        localparam logic [N-1:0] LO_M = ~({N{1'b1}} << K);
        localparam logic [N-1:0] HI_M = ~({N{1'b1}} >> K);
        logic         up_v, valid_q, rdy, sel;
        logic [N-1:0] up_d, data_q, data_d, sra;
        logic [S-1:0] up_sh, shamt_q;
        logic [1:0]   up_m, mode_q;
        if (i == 0) begin : g_src
            assign up_v  = in_valid;
            assign up_d  = in_data;
            assign up_sh = in_shamt;
            assign up_m  = in_mode;
        end else begin : g_src
            assign up_v  = g_stage[i-1].valid_q;
            assign up_d  = g_stage[i-1].data_q;
            assign up_sh = g_stage[i-1].shamt_q;
            assign up_m  = g_stage[i-1].mode_q;
        end
        if (i == S - 1) begin : g_rdy
            assign rdy = !valid_q || out_ready;
        end else begin : g_rdy
            assign rdy = !valid_q || g_stage[i+1].rdy;
        end
        assign sel    = up_sh[i];
        assign sra    = (up_d >> K) | ({N{up_d[N-1]}} & HI_M);
        assign data_d = !sel ? up_d :
                        up_m == 2'd0 ? up_d << K :
                        up_m == 2'd1 ? up_d >> K :
                        up_m == 2'd2 ? sra :
                        (up_d << KR) | (up_d >> (N - KR));
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                shamt_q <= '0;
                mode_q  <= '0;
            end else if (rdy) begin
                valid_q <= up_v;
                data_q  <= data_d;
                shamt_q <= up_sh;
                mode_q  <= up_m;
            end
        end
`ifdef PIPE_BARREL_STICKY_EN
        logic up_s, sticky_q, sticky_d;
        if (i == 0) begin : g_ssrc
            assign up_s = 1'b0;
        end else begin : g_ssrc
            assign up_s = g_stage[i-1].sticky_q;
        end
        assign sticky_d = up_s | (sel && (up_m == 2'd0 ? |(up_d & HI_M) :
                                          up_m == 2'd3 ? 1'b0 : |(up_d & LO_M)));
        always_ff @(posedge clk) begin
            if (rst)
                sticky_q <= 1'b0;
            else if (rdy)
                sticky_q <= sticky_d;
        end
`endif
    end

    assign in_ready    = g_stage[0].rdy && !rst;
    assign out_valid   = g_stage[S-1].valid_q;
    assign out_data    = g_stage[S-1].data_q;
    assign unused_last = ^{g_stage[S-1].shamt_q, g_stage[S-1].mode_q};
`ifdef PIPE_BARREL_STICKY_EN
    assign out_sticky  = g_stage[S-1].sticky_q;
`else
    assign out_sticky  = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// tb_pipe_barrel_shifter: directed vectors for pipe_barrel_shifter (N=16, S=4) with an in-order scoreboard.
module tb_pipe_barrel_shifter;
    typedef struct {
        logic [1:0]  m;
        logic [15:0] d;
        logic [3:0]  sh;
        logic [15:0] q;
        logic        st;
    } vec_t;

`ifdef PIPE_BARREL_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic [3:0]  in_shamt = '0;
    logic [1:0]  in_mode = '0;
    logic        in_ready, out_valid, out_sticky;
    logic [15:0] out_data;

    vec_t        tbl [17];
    int          sb [$];
    int          cur, n_chk, n_pass, lat, sent, c;
    logic        hold_chk;
    logic [15:0] held_d;
    logic        held_s;

    pipe_barrel_shifter #(.N(16), .S(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic drive(bit v, int idx);
        in_valid = v;
        cur      = idx;
        in_data  = tbl[idx].d;
        in_shamt = tbl[idx].sh;
        in_mode  = tbl[idx].m;
    endtask

    // One clock: check held outputs, retire/accept at mid-cycle, return 1 time unit after the edge.
    task automatic tick();
        int k;
        @(negedge clk);
        if (hold_chk) begin
            chk("hold_data", out_data, held_d);
            chk("hold_sticky", out_sticky, held_s);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", out_valid, 1'b0);
            else begin
                k = sb.pop_front();
                chk($sformatf("data[%0d]", k), out_data, tbl[k].q);
                chk($sformatf("sticky[%0d]", k), out_sticky, tbl[k].st & STK);
            end
        end
        if (in_valid && in_ready) sb.push_back(cur);
        hold_chk = out_valid && !out_ready && !rst;
        held_d   = out_data;
        held_s   = out_sticky;
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic single(int idx);
        drive(1'b1, idx);
        #1;
        chk("accept_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, idx);
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk($sformatf("latency[%0d]", idx), lat, 4);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("drained", sb.size(), 0);
    endtask

    initial begin
        tbl[0]  = '{2'd0, 16'h00F1, 4'd4,  16'h0F10, 1'b0};
        tbl[1]  = '{2'd2, 16'h8010, 4'd5,  16'hFC00, 1'b1};
        tbl[2]  = '{2'd1, 16'hFFFF, 4'd15, 16'h0001, 1'b1};
        tbl[3]  = '{2'd3, 16'h8001, 4'd15, 16'hC000, 1'b0};
        tbl[4]  = '{2'd3, 16'h1234, 4'd0,  16'h1234, 1'b0};
        tbl[5]  = '{2'd0, 16'h1234, 4'd0,  16'h1234, 1'b0};
        tbl[6]  = '{2'd0, 16'h8001, 4'd1,  16'h0002, 1'b1};
        tbl[7]  = '{2'd1, 16'h00F0, 4'd4,  16'h000F, 1'b0};
        tbl[8]  = '{2'd2, 16'h7FFF, 4'd15, 16'h0000, 1'b1};
        tbl[9]  = '{2'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0};
        tbl[10] = '{2'd3, 16'h1234, 4'd4,  16'h2341, 1'b0};
        tbl[11] = '{2'd0, 16'hFFFF, 4'd15, 16'h8000, 1'b1};
        tbl[12] = '{2'd1, 16'h8000, 4'd15, 16'h0001, 1'b0};
        tbl[13] = '{2'd3, 16'h0001, 4'd8,  16'h0100, 1'b0};
        tbl[14] = '{2'd2, 16'hF0F0, 4'd3,  16'hFE1E, 1'b0};
        tbl[15] = '{2'd0, 16'h1234, 4'd3,  16'h91A0, 1'b0};
        tbl[16] = '{2'd1, 16'h1235, 4'd1,  16'h091A, 1'b1};
        n_chk = 0; n_pass = 0; c = 0; hold_chk = 1'b0; cur = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_out_sticky", out_sticky, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 17; i++) single(i);

        // Back-to-back stream with out_ready low for cycles 3..8.
        c = 0; sent = 0;
        while (sent < 8 && c < 40) begin
            out_ready = !(c >= 3 && c <= 8);
            drive(1'b1, sent);
            #1;
            chk($sformatf("stream_in_ready_c%0d", c), in_ready, (c < 4 || c >= 9));
            if (in_ready) sent++;
            tick();
        end
        drive(1'b0, 0);
        out_ready = 1'b1;
        drain();

        // Bubble collapse: A at c0, B at c2, stall from c3; C, D still accepted, E refused.
        c = 0; sent = 0;
        while (c < 6) begin
            out_ready = (c < 3);
            drive(c == 0 || c == 2, c == 0 ? 8 : 9);
            tick();
        end
        drive(1'b1, 10);
        #1;
        chk("bubble_ready_c", in_ready, 1'b1);
        tick();
        drive(1'b1, 11);
        #1;
        chk("bubble_ready_d", in_ready, 1'b1);
        tick();
        drive(1'b1, 12);
        #1;
        chk("bubble_ready_e", in_ready, 1'b0);
        chk("bubble_out_valid", out_valid, 1'b1);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !(in_valid && in_ready); i++) tick();
        chk("bubble_e_taken", in_ready, 1'b1);
        tick();
        drive(1'b0, 0);
        drain();

        // Reset with three items in flight; only the post-reset operand may emerge.
        for (int i = 13; i < 16; i++) begin
            drive(1'b1, i);
            tick();
        end
        drive(1'b0, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", in_ready, 1'b0);
        tick();
        sb.delete();
        hold_chk = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        single(16);
        for (int i = 0; i < 6; i++) tick();
        chk("rst_mid_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
